// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding and the counter-width function used to size the bit counter.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Smallest w >= 1 with 2**w >= n.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - b_in, with borrow out.
// Purely combinational; the serial datapath uses a single instance.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic b_in,
   output logic d_out,
   output logic b_out
);

   assign d_out = x ^ y ^ b_in;
   assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, behind a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add a registered signed-overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             bo_q, bo_d;
   logic             d_bit, b_bit;
   logic             last;

   full_subtractor u_fs (
      .x     (a_q[0]),
      .y     (b_q[0]),
      .b_in  (brw_q),
      .d_out (d_bit),
      .b_out (b_bit)
   );

   assign last = (state_q == RUN) && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q == RUN);
      done       = (state_q == DONE);
      diff       = diff_q;
      borrow_out = bo_q;
   end

   // Result bits enter a_q's MSB as operand bits leave its LSB.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      brw_d  = brw_q;
      cnt_d  = cnt_q;
      diff_d = diff_q;
      bo_d   = bo_q;
      if (state_q == IDLE && start) begin
         a_d   = a;
         b_d   = b;
         brw_d = 1'b0;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         a_d   = {d_bit, a_q[WIDTH-1:1]};
         b_d   = {1'b0, b_q[WIDTH-1:1]};
         brw_d = b_bit;
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            diff_d = a_d;
            bo_d   = b_bit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         brw_q  <= 1'b0;
         cnt_q  <= '0;
         diff_q <= '0;
         bo_q   <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         brw_q  <= brw_d;
         cnt_q  <= cnt_d;
         diff_q <= diff_d;
         bo_q   <= bo_d;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic am_q, bm_q, ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         am_q  <= 1'b0;
         bm_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (state_q == IDLE && start) begin
            am_q <= a[WIDTH-1];
            bm_q <= b[WIDTH-1];
         end
         if (last) ovf_q <= (am_q != bm_q) && (d_bit != am_q);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level model plus directed literal checks.
// Build with SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, borrow_out;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   logic fx, fy, fbi, fd, fbo;

   full_subtractor u_cell (
      .x     (fx),
      .y     (fy),
      .b_in  (fbi),
      .d_out (fd),
      .b_out (fbo)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit sovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int sx, sy, r;
      sx = int'($signed(x));
      sy = int'($signed(y));
      r  = sx - sy;
      return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
   endfunction

   // Model: edges counted since reset; an accepted start at edge k puts
   // busy after edges k..k+W-1, done and the new result after edge k+W.
   int           e = 0, k = 0;
   bit           act = 1'b0;
   logic [W-1:0] pd = '0, xd = '0;
   bit           pb = 1'b0, xb = 1'b0, po = 1'b0, xo = 1'b0;
   int           n_done_model = 0;
   int           n_done_dut = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e   <= 0;
         k   <= 0;
         act <= 1'b0;
         xd  <= '0;
         xb  <= 1'b0;
         xo  <= 1'b0;
      end else begin
         e <= e + 1;
         if ((!act || (e - k) >= W + 1) && start) begin
            act <= 1'b1;
            k   <= e + 1;
            pd  <= a - b;
            pb  <= (a < b);
            po  <= sovf(a, b);
         end else if (act && (e + 1 - k) == W) begin
            xd <= pd;
            xb <= pb;
            xo <= po;
            n_done_model <= n_done_model + 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(act && (e - k) < W));
      chk("done", 32'(done), 32'(act && (e - k) == W));
      chk("diff", 32'(diff), 32'(xd));
      chk("borrow_out", 32'(borrow_out), 32'(xb));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", 32'(ovf), 32'(xo));
`endif
      if (done === 1'b1) n_done_dut++;
   end

   task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [W-1:0] ed, input logic eb);
      int n, nb;
      bit seen;
      @(negedge clk);
      start = 1'b1;
      a = ia;
      b = ib;
      n = 0;
      nb = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         a = W'($urandom);
         b = W'($urandom);
         if (busy) nb++;
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", n, W + 1);
      chk("busy_cycles", nb, W);
      chk("diff_lit", 32'(diff), 32'(ed));
      chk("borrow_lit", 32'(borrow_out), 32'(eb));
      @(negedge clk);
   endtask

   initial begin
      int r, gap;
      bit seen;
      logic [W-1:0] x, y;

      for (int i = 0; i < 8; i++) begin
         {fx, fy, fbi} = i[2:0];
         #1;
         r = int'(fx) - int'(fy) - int'(fbi);
         chk("fs_d", 32'(fd), 32'(r & 1));
         chk("fs_b", 32'(fbo), 32'(r < 0));
      end

      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      op(8'h5A, 8'h3C, 8'h1E, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf_5a_3c", 32'(ovf), 32'd0);
`endif
      op(8'h00, 8'h01, 8'hFF, 1'b1);
      op(8'h37, 8'h37, 8'h00, 1'b0);
      op(8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf_80_01", 32'(ovf), 32'd1);
`endif
      op(8'h7F, 8'hFF, 8'h80, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf_7f_ff", 32'(ovf), 32'd1);
`endif
      op(8'h00, 8'hFF, 8'h01, 1'b1);

      // start held high; operands change during the first run
      @(negedge clk);
      start = 1'b1;
      a = 8'h10;
      b = 8'h01;
      repeat (4) @(negedge clk);
      a = 8'hFF;
      b = 8'hFF;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      chk("hold_done1", 32'(seen), 32'd1);
      chk("hold_diff1", 32'(diff), 32'h0F);
      seen = 1'b0;
      gap = 0;
      while (!seen && gap < 30) begin
         @(negedge clk);
         gap++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk("hold_gap", gap, 10);
      chk("hold_diff2", 32'(diff), 32'h00);
      chk("hold_borrow2", 32'(borrow_out), 32'd0);
      repeat (2) @(negedge clk);

      // asynchronous reset in the middle of a run
      op(8'h5A, 8'h3C, 8'h1E, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a = 8'h00;
      b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_diff", 32'(diff), 32'd0);
      chk("mid_rst_borrow", 32'(borrow_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      op(8'h09, 8'h03, 8'h06, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         op(x, y, x - y, x < y);
      end

      repeat (3) @(negedge clk);
      chk("done_pulses", n_done_dut, 1010);
      chk("done_vs_model", n_done_dut, n_done_model);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
